aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Parametrised successor to the single-mode encryption round controller. Sequences the AES datapath through initial, middle and last rounds for 128/192/256-bit keys in encrypt or decrypt mode. Supports a configurable number of cycles per round and provides a start/busy/done handshake. Sits between the host/DMA command interface and the round datapath and key schedule; it drives the round type, round index and key-schedule index.

Parameters:
CYCLES_PER_ROUND, 3, cycles spent in each MID round (>=1)
LAST_ROUND_CYCLES, 2, cycles spent in the LAST round (>=1; no MixColumns stage)
CW, derived, round_cycle width = max(1, $clog2(max(CYCLES_PER_ROUND, LAST_ROUND_CYCLES)))

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
key_len  in  2  0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=illegal
decrypt  in  1  0=encrypt, 1=decrypt; latched with start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on completion
cfg_err  out  1  one-cycle pulse when start is rejected for key_len==3
state  out  2  0=IDLE, 1=INITIAL_ROUND, 2=MID_ROUND, 3=LAST_ROUND
round_idx  out  4  current round number, 0..Nr
round_cycle  out  CW  cycle within the current round
key_idx  out  4  round-key index: encrypt = round_idx, decrypt = Nr - round_idx
round_end  out  1  high on the final cycle of each round, INITIAL included
mode_dec  out  1  latched decrypt flag

Behaviour:
- Reset (when reset=1 at a clk edge): state=IDLE, round_idx=0, round_cycle=0, key_idx=0, busy=0, done=0, cfg_err=0, round_end=0, mode_dec=0, latched Nr=10. Reset overrides all other inputs. Reset in mid-operation returns to IDLE on the next edge with no done pulse.
- IDLE, start=1, key_len!=3: latch Nr and decrypt. Next state is INITIAL_ROUND with round_idx=0 and round_cycle=0.
- IDLE, start=1, key_len==3: stay in IDLE and pulse cfg_err for 1 cycle. busy stays 0.
- INITIAL_ROUND: lasts 1 cycle (AddRoundKey only), round_end=1. Then MID_ROUND with round_idx=1 and round_cycle=0.
- MID_ROUND: round_cycle counts 0..CYCLES_PER_ROUND-1. round_end=1 at the last count, then round_cycle wraps to 0 and round_idx increments.
  - If round_idx was Nr-1 at that point, the next state is LAST_ROUND with round_idx=Nr.
- LAST_ROUND: round_cycle counts 0..LAST_ROUND_CYCLES-1. round_end=1 at the last count, then the next state is IDLE.
- done is registered: it is 1 during the first IDLE cycle after LAST_ROUND, and 0 otherwise.
- Busy duration = 1 + (Nr-1)*CYCLES_PER_ROUND + LAST_ROUND_CYCLES. With defaults: 30 (128-bit), 36 (192-bit), 42 (256-bit).
- start while busy is ignored. key_len and decrypt changes while busy have no effect.
- start=1 in the done cycle is accepted (back-to-back operation). With start held high, IDLE lasts exactly 1 cycle between operations.
- key_idx is combinational from round_idx, the latched Nr and mode_dec; it is valid in every non-IDLE state. In IDLE, key_idx=0.

Optional Feature:
Macro AES_SEQ_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 while busy forces state to IDLE on the next edge and clears round_idx and round_cycle. done is not pulsed. aborted (an added 1-bit output) pulses for 1 cycle. abort in IDLE is ignored. If abort and start are both high in IDLE, start wins.
- Undefined: no abort or aborted ports. Only reset can terminate an operation.

Test Plan:
- Reset, then start=1 with key_len=0, decrypt=0 -> INITIAL for 1 cycle, MID for 27 cycles (round_idx 1..9, round_cycle 0,1,2 repeating), LAST for 2 cycles (round_idx=10), then IDLE with done=1 for exactly 1 cycle. busy is high for 30 cycles.
- key_len=2, decrypt=1 -> busy for 42 cycles. key_idx goes 14 at INITIAL, 13..1 across MID, 0 at LAST. mode_dec=1.
- key_len=3 with start -> cfg_err pulses once, state stays IDLE, busy=0, done never asserts.
- start held high across two AES-192 operations -> second INITIAL_ROUND begins in the cycle after the done cycle. Pulse start again mid-operation -> ignored, round count unaffected.
- Assert reset at MID_ROUND round_idx=5 -> next cycle state=IDLE, round_idx=0, busy=0, no done. A subsequent start runs a full 30-cycle operation.
- With AES_SEQ_ABORT_EN: abort during LAST_ROUND -> IDLE on the next edge, aborted=1 for 1 cycle, done=0. Without the macro the bench compiles with no abort port.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: walks the datapath through INITIAL, MID and LAST rounds for AES-128/192/256.
// Optional abort port/aborted pulse enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer #(
  parameter int unsigned CYCLES_PER_ROUND  = 3,
  parameter int unsigned LAST_ROUND_CYCLES = 2,
  localparam int unsigned MAX_CYC = (CYCLES_PER_ROUND > LAST_ROUND_CYCLES) ?
                                    CYCLES_PER_ROUND : LAST_ROUND_CYCLES,
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    key_len,
  input  logic          decrypt,
`ifdef AES_SEQ_ABORT_EN
  input  logic          abort,
  output logic          aborted,
`endif
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [1:0]    state,
  output logic [3:0]    round_idx,
  output logic [CW-1:0] round_cycle,
  output logic [3:0]    key_idx,
  output logic          round_end,
  output logic          mode_dec
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INITIAL = 2'd1,
    S_MID     = 2'd2,
    S_LAST    = 2'd3
  } state_e;

  localparam logic [CW-1:0] MID_LAST_CYC  = CW'(CYCLES_PER_ROUND - 1);
  localparam logic [CW-1:0] LAST_LAST_CYC = CW'(LAST_ROUND_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    round_idx_q, round_idx_d;
  logic [CW-1:0] round_cycle_q, round_cycle_d;
  logic [3:0]    nr_q, nr_d;
  logic          mode_dec_q, mode_dec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          round_end_q, round_end_d;
  logic          aborted_q, aborted_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    round_idx_d   = round_idx_q;
    round_cycle_d = round_cycle_q;
    nr_d          = nr_q;
    mode_dec_d    = mode_dec_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    aborted_d     = 1'b0;
    round_end_d   = 1'b0;
    busy_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (key_len == 2'd3) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d       = S_INITIAL;
            round_idx_d   = 4'd0;
            round_cycle_d = '0;
            mode_dec_d    = decrypt;
            case (key_len)
              2'd1:    nr_d = 4'd12;
              2'd2:    nr_d = 4'd14;
              default: nr_d = 4'd10;
            endcase
          end
        end
      end
      S_INITIAL: begin
        state_d       = S_MID;
        round_idx_d   = 4'd1;
        round_cycle_d = '0;
      end
      S_MID: begin
        if (round_cycle_q == MID_LAST_CYC) begin
          round_cycle_d = '0;
          round_idx_d   = round_idx_q + 4'd1;
          if (round_idx_q == nr_q - 4'd1) begin
            state_d = S_LAST;
          end
        end else begin
          round_cycle_d = round_cycle_q + CW'(1);
        end
      end
      S_LAST: begin
        if (round_cycle_q == LAST_LAST_CYC) begin
          state_d       = S_IDLE;
          round_idx_d   = 4'd0;
          round_cycle_d = '0;
          done_d        = 1'b1;
        end else begin
          round_cycle_d = round_cycle_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AES_SEQ_ABORT_EN
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      round_idx_d   = 4'd0;
      round_cycle_d = '0;
      done_d        = 1'b0;
      aborted_d     = 1'b1;
    end
`endif

    // round_end is registered, so it is derived from the upcoming round position
    case (state_d)
      S_INITIAL: round_end_d = 1'b1;
      S_MID:     round_end_d = (round_cycle_d == MID_LAST_CYC);
      S_LAST:    round_end_d = (round_cycle_d == LAST_LAST_CYC);
      default:   round_end_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      round_idx_q   <= 4'd0;
      round_cycle_q <= '0;
      nr_q          <= 4'd10;
      mode_dec_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      round_end_q   <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_idx_q   <= round_idx_d;
      round_cycle_q <= round_cycle_d;
      nr_q          <= nr_d;
      mode_dec_q    <= mode_dec_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      round_end_q   <= round_end_d;
      aborted_q     <= aborted_d;
    end
  end

  // Decrypt walks the key schedule backwards
  always_comb begin
    if (state_q == S_IDLE) begin
      key_idx = 4'd0;
    end else if (mode_dec_q) begin
      key_idx = nr_q - round_idx_q;
    end else begin
      key_idx = round_idx_q;
    end
  end

  assign state       = state_q;
  assign round_idx   = round_idx_q;
  assign round_cycle = round_cycle_q;
  assign mode_dec    = mode_dec_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign round_end   = round_end_q;

`ifdef AES_SEQ_ABORT_EN
  assign aborted = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer (default parameters); abort tests under AES_SEQ_ABORT_EN.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] key_len;
  logic       decrypt;
  logic       busy, done, cfg_err, round_end, mode_dec;
  logic [1:0] state;
  logic [3:0] round_idx, key_idx;
  logic [1:0] round_cycle;
`ifdef AES_SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  aes_round_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key_len     (key_len),
    .decrypt     (decrypt),
`ifdef AES_SEQ_ABORT_EN
    .abort       (abort),
    .aborted     (aborted),
`endif
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .state       (state),
    .round_idx   (round_idx),
    .round_cycle (round_cycle),
    .key_idx     (key_idx),
    .round_end   (round_end),
    .mode_dec    (mode_dec)
  );

  always #5 clk = ~clk;

  // kind: 0 = completed operation (done), 1 = rejected start (cfg_err), 2 = aborted
  typedef struct {
    int kind;
    int nr;
    int len;
    bit dec;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nr_of(input logic [1:0] kl);
    case (kl)
      2'd1:    return 12;
      2'd2:    return 14;
      default: return 10;
    endcase
  endfunction

  function automatic int len_of(input logic [1:0] kl);
    case (kl)
      2'd1:    return 36;
      2'd2:    return 42;
      default: return 30;
    endcase
  endfunction

  function automatic exp_t mk_op(input logic [1:0] kl, input bit dec);
    exp_t e;
    e.kind = 0; e.nr = nr_of(kl); e.len = len_of(kl); e.dec = dec;
    return e;
  endfunction

  // Monitor: tracks each busy window and scores it when done/cfg_err/aborted appears
  int bcnt = 0, recnt = 0, first_key = -1, last_key = -1, last_ri = -1;
  bit prev_busy = 1'b0, chk_done_low = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (busy && !prev_busy) begin
      bcnt = 1; recnt = 0; first_key = -1; last_key = -1; last_ri = -1;
    end else if (busy) begin
      bcnt++;
    end
    if (round_end) begin
      recnt++;
      if (state == 2'd1) first_key = int'(key_idx);
      if (state == 2'd2) begin
        chk("mid_round_end_cycle", int'(round_cycle), 2);
        if (sb.size() > 0 && sb[0].kind == 0)
          chk("mid_key_idx", int'(key_idx),
              sb[0].dec ? sb[0].nr - int'(round_idx) : int'(round_idx));
      end
      if (state == 2'd3) begin
        last_key = int'(key_idx);
        last_ri  = int'(round_idx);
        chk("last_round_end_cycle", int'(round_cycle), 1);
      end
    end
    if (chk_done_low) begin
      chk("done_one_cycle", int'(done), 0);
      chk_done_low = 1'b0;
    end
    if (done === 1'b1) begin
      chk_done_low = 1'b1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("done_kind", 0, e.kind);
        chk("busy_len", bcnt, e.len);
        chk("round_end_count", recnt, e.nr + 1);
        chk("initial_key_idx", first_key, e.dec ? e.nr : 0);
        chk("last_key_idx", last_key, e.dec ? 0 : e.nr);
        chk("last_round_idx", last_ri, e.nr);
        chk("mode_dec", int'(mode_dec), int'(e.dec));
        chk("done_state_idle", int'(state), 0);
      end
    end
    if (cfg_err === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cfg_err: got cfg_err=1 expected none (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("cfg_err_kind", 1, e.kind);
        chk("cfg_err_busy", int'(busy), 0);
      end
    end
`ifdef AES_SEQ_ABORT_EN
    if (aborted === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_aborted: got aborted=1 expected none (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("aborted_kind", 2, e.kind);
        chk("aborted_done", int'(done), 0);
      end
    end
`endif
    prev_busy = (busy === 1'b1);
  end

  task automatic wait_done(input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", lim);
    end
  endtask

  task automatic wait_pos(input int st, input int ri, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (int'(state) == st && int'(round_idx) == ri) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL pos_timeout: got state %0d idx %0d expected state %0d idx %0d",
               state, round_idx, st, ri);
    end
  endtask

  task automatic run_op(input logic [1:0] kl, input bit dec);
    @(posedge clk); #1;
    start = 1'b1; key_len = kl; decrypt = dec;
    sb.push_back(mk_op(kl, dec));
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_state_initial", int'(state), 1);
    wait_done(100);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; start = 1'b0; key_len = 2'd0; decrypt = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_state", int'(state), 0);
    chk("rst_round_idx", int'(round_idx), 0);
    chk("rst_round_cycle", int'(round_cycle), 0);
    chk("rst_key_idx", int'(key_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_round_end", int'(round_end), 0);
    chk("rst_mode_dec", int'(mode_dec), 0);

    run_op(2'd0, 1'b0);
    run_op(2'd2, 1'b1);

    // Illegal key length is rejected without leaving IDLE
    @(posedge clk); #1;
    start = 1'b1; key_len = 2'd3;
    e.kind = 1; e.nr = 0; e.len = 0; e.dec = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_state_idle", int'(state), 0);
    chk("cfg_busy", int'(busy), 0);
    chk("cfg_err_pulse", int'(cfg_err), 1);
    @(posedge clk); #1;
    chk("cfg_err_one_cycle", int'(cfg_err), 0);
    repeat (40) @(posedge clk);

    // Back-to-back AES-192 with start held; input changes while busy must not matter
    @(posedge clk); #1;
    start = 1'b1; key_len = 2'd1; decrypt = 1'b0;
    sb.push_back(mk_op(2'd1, 1'b0));
    sb.push_back(mk_op(2'd1, 1'b1));
    @(posedge clk); #1;
    decrypt = 1'b1; key_len = 2'd3;
    repeat (5) @(posedge clk);
    #1 key_len = 2'd1;
    wait_done(100);
    @(posedge clk); #1;
    chk("b2b_second_initial", int'(state), 1);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);

    // Reset in the middle of MID round 5 returns to IDLE with no done
    @(posedge clk); #1;
    start = 1'b1; key_len = 2'd0; decrypt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_pos(2, 5, 60);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_state", int'(state), 0);
    chk("midrst_round_idx", int'(round_idx), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    run_op(2'd0, 1'b0);

`ifdef AES_SEQ_ABORT_EN
    // Abort during LAST round
    @(posedge clk); #1;
    start = 1'b1; key_len = 2'd0; decrypt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_pos(3, 10, 60);
    abort = 1'b1;
    e.kind = 2; e.nr = 0; e.len = 0; e.dec = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_state", int'(state), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pulse", int'(aborted), 1);
    @(posedge clk); #1;
    chk("abort_one_cycle", int'(aborted), 0);
    // Abort together with start in IDLE: start wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; key_len = 2'd0; decrypt = 1'b0;
    sb.push_back(mk_op(2'd0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_wins", int'(state), 1);
    wait_done(100);
`endif

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
